count_monitor: RTL and testbench
================================

Name: count_monitor

Overview:
Receive-side checker for the free-running up/down counter's count bus. Samples the count value each enabled cycle and recovers the counter's mode bit (up = 1, down = 0). Flags wrap-around, counter resets, and illegal steps, and maintains a saturating error tally. Sits downstream of the counter in the exp1 counter test harness and on-chip self-check path.

Parameters:
W, 32, width of the monitored count bus
LOCK_N, 4, consecutive legal same-direction steps required to assert lock (range 2..15)
ECW, 16, width of the saturating error counter

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous active-high reset
en  input  1  sample qualifier; count_in is sampled only when en=1
count_in  input  W  observed counter value
dir  output  1  recovered mode (1 = counting up, 0 = counting down)
locked  output  1  direction tracking established
step_ok  output  1  one-cycle pulse: last sample was a legal ±1 step
wrap  output  1  one-cycle pulse: legal step crossed all-ones<->0
rst_seen  output  1  one-cycle pulse: counter reset detected
err  output  1  one-cycle pulse: illegal step detected
err_sticky  output  1  set on any err; cleared only by rst
err_cnt  output  ECW  saturating count of err pulses

Behaviour:
- Reset:
  - Synchronous, active-high, evaluated on the rising clock edge.
  - Asserting rst at any time, including mid-tracking, forces state=IDLE, prev=0, run=0 and all outputs to 0 (dir=0, err_cnt=0) on that edge.
  - rst overrides en.
- Outputs are all registered. Results for a sample taken at edge N appear after edge N, i.e. 1-cycle latency.
- Pulse outputs (step_ok, wrap, rst_seen, err) are 0 on any cycle following en=0.
- en=0 leaves prev, state, run, dir and locked unchanged. An en gap is not an error.
- Step classification: delta = count_in - prev, modulo 2^W. Checks are applied in this priority order:
  1. delta == 1: up step. step_ok=1, dir<=1. wrap=1 if prev == all-ones.
  2. delta == 2^W-1: down step. step_ok=1, dir<=0. wrap=1 if prev == 0.
  3. count_in == 0, otherwise: counter reset. rst_seen=1, run<=0, locked<=0, no error.
  4. Otherwise, including delta == 0 (hold): err=1, err_sticky<=1, err_cnt increments and saturates at 2^ECW-1, run<=0, locked<=0. dir keeps its value.
- Because rule 1 precedes rule 3, the step all-ones->0 is a wrap, not a reset. By the same priority, 1->0 is a down step.
- prev<=count_in on every enabled sample, regardless of classification.
- State machine:
  - IDLE:
    - First en=1 sample: prev<=count_in, no classification, no pulses, go TRACK. run=0.
  - TRACK:
    - Classify each enabled sample.
    - Legal step in the same direction as the previous legal step: run<=min(run+1, LOCK_N).
    - Legal step in the opposite direction, or first step after run=0: run<=1, locked<=0.
    - locked<=1 when run reaches LOCK_N.
    - While locked, a direction reversal drops lock and restarts run at 1. The mode input may legitimately toggle, so this is not an error.
  - No path returns to IDLE except rst.
- Simultaneous wrap and direction change (e.g. prev=0, count_in=all-ones after up steps): wrap=1, step_ok=1, dir<=0, run<=1, locked<=0.
- err_sticky and err_cnt are unaffected by rst_seen events.

Test Plan:
1. Up run with no wrap: rst, then en=1 with count_in 5,6,7,8,9 -> step_ok pulses from the 2nd sample; dir=1; locked=1 after the sample 9 edge; err_cnt=0.
2. Wrap both ways: feed FFFFFFFE, FFFFFFFF, 0, 1 -> wrap=1 only for FFFFFFFF->0; no rst_seen. Then feed 1, 0, FFFFFFFF -> wrap=1 on 0->FFFFFFFF; dir=0.
3. Counter reset: locked up-run at 100,101,102,103,104, then 0, then 1 -> rst_seen=1 for the 0 sample, locked=0, err=0; tracking restarts with run=1 after the sample 1.
4. Illegal steps and saturation (ECW=2 build): feed 10, 10, 13, 20, 7 -> err pulses on all four, err_cnt=3 (saturated), err_sticky=1, dir unchanged.
5. en gaps and direction reversal: 50,51,52,53,54 locked up, en=0 for 3 cycles with count_in=999, then 53 -> no err; dir=0; locked=0; run=1.
6. Reset mid-operation: assert rst for one cycle during a locked run -> next cycle all outputs 0; the first sample afterwards produces no pulse (IDLE priming).

Source files
------------

// File: rtl/count_monitor.sv
// rtl/count_monitor.sv - receive-side checker for an up/down counter's count bus
module count_monitor #(
    parameter int W      = 32,
    parameter int LOCK_N = 4,
    parameter int ECW    = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic [W-1:0]   count_in,
    output logic           dir,
    output logic           locked,
    output logic           step_ok,
    output logic           wrap,
    output logic           rst_seen,
    output logic           err,
    output logic           err_sticky,
    output logic [ECW-1:0] err_cnt
);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_TRACK = 1'b1;
    localparam logic [3:0] LOCK_V  = 4'(LOCK_N);

    logic [0:0]   state;
    logic [W-1:0] prev;
    logic [3:0]   run;

    logic [W-1:0] delta;
    logic         is_up;
    logic         is_dn;
    logic         same_dir;
    logic [3:0]   run_nxt;

    always_comb begin
        delta    = count_in - prev;
        is_up    = (delta == W'(1));
        is_dn    = (delta == {W{1'b1}});
        // a run only continues if a previous legal step exists and it went the same way
        same_dir = (run != 4'd0) && (dir == is_up);
        run_nxt  = 4'd1;
        if (same_dir)
            run_nxt = (run >= LOCK_V) ? LOCK_V : run + 4'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            prev       <= '0;
            run        <= '0;
            dir        <= 1'b0;
            locked     <= 1'b0;
            step_ok    <= 1'b0;
            wrap       <= 1'b0;
            rst_seen   <= 1'b0;
            err        <= 1'b0;
            err_sticky <= 1'b0;
            err_cnt    <= '0;
        end else begin
            step_ok  <= 1'b0;
            wrap     <= 1'b0;
            rst_seen <= 1'b0;
            err      <= 1'b0;
            if (en) begin
                prev <= count_in;
                if (state == S_IDLE) begin
                    state <= S_TRACK;
                end else if (is_up || is_dn) begin
                    step_ok <= 1'b1;
                    wrap    <= is_up ? (prev == {W{1'b1}}) : (prev == '0);
                    dir     <= is_up;
                    run     <= run_nxt;
                    locked  <= (run_nxt == LOCK_V);
                end else if (count_in == '0) begin
                    rst_seen <= 1'b1;
                    run      <= '0;
                    locked   <= 1'b0;
                end else begin
                    err        <= 1'b1;
                    err_sticky <= 1'b1;
                    if (err_cnt != {ECW{1'b1}})
                        err_cnt <= err_cnt + 1'b1;
                    run    <= '0;
                    locked <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_count_monitor.sv
// tb/tb_count_monitor.sv - scoreboard bench for count_monitor
module tb_count_monitor;

    localparam int LOCK = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [31:0] count_in = '0;

    logic        dir, locked, step_ok, wrap, rst_seen, err, err_sticky;
    logic [15:0] err_cnt;
    logic        dir2, locked2, step_ok2, wrap2, rst_seen2, err2, err_sticky2;
    logic [1:0]  err_cnt2;

    always #5 clk = ~clk;

    count_monitor #(.W(32), .LOCK_N(LOCK), .ECW(16)) dut (
        .clk(clk), .rst(rst), .en(en), .count_in(count_in),
        .dir(dir), .locked(locked), .step_ok(step_ok), .wrap(wrap),
        .rst_seen(rst_seen), .err(err), .err_sticky(err_sticky), .err_cnt(err_cnt)
    );

    count_monitor #(.W(32), .LOCK_N(LOCK), .ECW(2)) dut2 (
        .clk(clk), .rst(rst), .en(en), .count_in(count_in),
        .dir(dir2), .locked(locked2), .step_ok(step_ok2), .wrap(wrap2),
        .rst_seen(rst_seen2), .err(err2), .err_sticky(err_sticky2), .err_cnt(err_cnt2)
    );

    typedef struct packed {
        logic        dir, locked, step_ok, wrap, rst_seen, err, sticky;
        logic [15:0] cnt;
        logic [1:0]  cnt2;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_pass   = 0;

    // reference state
    logic        m_track;
    logic [31:0] m_prev;
    int          m_run;
    exp_t        m;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic model(input logic r, input logic e, input logic [31:0] v);
        logic [31:0] d;
        logic up;
        if (r) begin
            m_track = 0; m_prev = 0; m_run = 0; m = '0;
        end else begin
            m.step_ok = 0; m.wrap = 0; m.rst_seen = 0; m.err = 0;
            if (e) begin
                if (!m_track) begin
                    m_track = 1;
                end else begin
                    d = v - m_prev;
                    if (d == 32'd1 || d == 32'hFFFF_FFFF) begin
                        up = (d == 32'd1);
                        m.step_ok = 1;
                        m.wrap = up ? (m_prev == 32'hFFFF_FFFF) : (m_prev == 32'd0);
                        if (m_run == 0 || m.dir != up) m_run = 1;
                        else if (m_run < LOCK) m_run = m_run + 1;
                        m.dir = up;
                        m.locked = (m_run == LOCK);
                    end else if (v == 0) begin
                        m.rst_seen = 1; m_run = 0; m.locked = 0;
                    end else begin
                        m.err = 1; m.sticky = 1; m_run = 0; m.locked = 0;
                        if (m.cnt != 16'hFFFF) m.cnt = m.cnt + 16'd1;
                        if (m.cnt2 != 2'd3) m.cnt2 = m.cnt2 + 2'd1;
                    end
                end
                m_prev = v;
            end
        end
    endtask

    task automatic step(input logic r, input logic e, input logic [31:0] v);
        exp_t x;
        model(r, e, v);
        sb.push_back(m);
        rst = r; en = e; count_in = v;
        @(posedge clk);
        #1;
        x = sb.pop_front();
        check_eq("dir", dir, x.dir);
        check_eq("locked", locked, x.locked);
        check_eq("step_ok", step_ok, x.step_ok);
        check_eq("wrap", wrap, x.wrap);
        check_eq("rst_seen", rst_seen, x.rst_seen);
        check_eq("err", err, x.err);
        check_eq("err_sticky", err_sticky, x.sticky);
        check_eq("err_cnt", err_cnt, x.cnt);
        check_eq("err_cnt_ecw2", err_cnt2, x.cnt2);
        check_eq("err_ecw2", err2, x.err);
        check_eq("locked_ecw2", locked2, x.locked);
    endtask

    task automatic feed(input logic [31:0] v);
        step(1'b0, 1'b1, v);
    endtask

    logic [31:0] rv;

    initial begin
        m_track = 0; m_prev = 0; m_run = 0; m = '0;
        step(1'b1, 1'b0, 32'd0);
        step(1'b1, 1'b1, 32'd7);
        check_eq("reset_err_cnt", err_cnt, 32'd0);

        // up run, no wrap
        feed(5); feed(6); feed(7); feed(8); feed(9);
        check_eq("t1_locked", locked, 32'd1);
        check_eq("t1_dir", dir, 32'd1);

        // wraps in both directions
        step(1'b1, 1'b0, 0);
        feed(32'hFFFF_FFFE); feed(32'hFFFF_FFFF); feed(0);
        check_eq("t2_wrap_up", wrap, 32'd1);
        feed(1);
        check_eq("t2_no_wrap", wrap, 32'd0);
        step(1'b1, 1'b0, 0);
        feed(1); feed(0);
        check_eq("t2_down_not_reset", rst_seen, 32'd0);
        feed(32'hFFFF_FFFF);
        check_eq("t2_wrap_dn", wrap, 32'd1);
        check_eq("t2_dir", dir, 32'd0);

        // counter reset detection
        step(1'b1, 1'b0, 0);
        feed(100); feed(101); feed(102); feed(103); feed(104);
        feed(0);
        check_eq("t3_rst_seen", rst_seen, 32'd1);
        check_eq("t3_unlocked", locked, 32'd0);
        feed(1);
        check_eq("t3_restart", step_ok, 32'd1);

        // illegal steps and ECW=2 saturation
        step(1'b1, 1'b0, 0);
        feed(10); feed(10); feed(13); feed(20); feed(7);
        check_eq("t4_sat", err_cnt2, 32'd3);
        check_eq("t4_cnt", err_cnt, 32'd4);

        // en gap then reversal
        step(1'b1, 1'b0, 0);
        feed(50); feed(51); feed(52); feed(53); feed(54);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'd999);
        check_eq("t5_gap_locked", locked, 32'd1);
        feed(53);
        check_eq("t5_dir", dir, 32'd0);
        check_eq("t5_unlocked", locked, 32'd0);
        check_eq("t5_no_err", err, 32'd0);

        // reset mid-run then prime
        feed(52); feed(51); feed(50); feed(49);
        step(1'b1, 1'b1, 48);
        check_eq("t6_rst_locked", locked, 32'd0);
        feed(47);
        check_eq("t6_prime_no_pulse", step_ok, 32'd0);

        // random walk with gaps, jumps, resets
        rv = 32'hFFFF_FFF0;
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 15))
                0:       rv = $urandom;
                1:       rv = 0;
                2:       rv = rv;
                3, 4:    rv = rv - 1;
                default: rv = rv + 1;
            endcase
            step(($urandom_range(0, 63) == 0), ($urandom_range(0, 5) != 0), rv);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
